dm_cache_core: RTL and testbench

Parametrised direct-mapped data cache core. It replaces the fixed 15-bit, 4-word-block cache/memory pairing with configurable address, index and block geometry. It adds a valid/ready CPU request port, a multi-beat memory refill handshake, write-through on writes, a flush command, and saturating hit/access counters. It sits between the request source (address reader) and the backing data memory.

---
 rtl/dm_cache_pkg.sv | 20 ++
 rtl/dm_cache_store.sv | 55 +++++
 rtl/dm_cache_core.sv | 175 +++++++++++++++++
 tb/tb_dm_cache_core.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache core.
package dm_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        RESP
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int tag_w(input int addr_w, input int index_w, input int words);
        return addr_w - index_w - $clog2(words);
    endfunction

endpackage

// File: rtl/dm_cache_store.sv
// Line storage: valid vector with single-cycle clear, tag array and word-addressed data array.
module dm_cache_store #(
    parameter int INDEX_W = 10,
    parameter int OFF_W   = 2,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_all,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [OFF_W-1:0]   rd_off,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               word_we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [OFF_W-1:0]   wr_off,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               line_we,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFF_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (line_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are don't-care until the valid bit says otherwise.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[wr_index] <= wr_tag;
        end
        if (word_we) begin
            data[{wr_index, wr_off}] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_off}];

endmodule

// File: rtl/dm_cache_core.sv
// Direct-mapped cache core: read-allocate with multi-beat refill, write-through no-allocate writes.
module dm_cache_core
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 10,
    parameter int WORDS   = 4,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic               resp_hit,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_wack,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] access_count
);

    localparam int OFF_W = off_w(WORDS);
    localparam int TAG_W = tag_w(ADDR_W, INDEX_W, WORDS);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                hit_q;
    logic [OFF_W-1:0]    beat;

    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  index_q;
    logic [OFF_W-1:0]    off_q;
    logic                rd_valid, lookup_hit, last_beat, accept;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                clear_all, word_we, line_we;
    logic [OFF_W-1:0]    wr_off;
    logic [DATA_W-1:0]   wr_data;

    assign tag_q      = addr_q[ADDR_W-1 -: TAG_W];
    assign index_q    = addr_q[OFF_W +: INDEX_W];
    assign off_q      = addr_q[OFF_W-1:0];
    assign lookup_hit = rd_valid && (rd_tag == tag_q);
    assign last_beat  = mem_rvalid && (beat == OFF_W'(WORDS - 1));

    // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_valid may be held or dropped freely, and responses cannot be stalled.
    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clear_all  = 1'b0;
        word_we    = 1'b0;
        line_we    = 1'b0;
        wr_off     = off_q;
        wr_data    = wdata_q;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_hit   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                clear_all = flush;
                if (accept) state_nx = LOOKUP;
            end
            LOOKUP: begin
                word_we = we_q && lookup_hit;
                if (we_q)            state_nx = WRITE;
                else if (lookup_hit) state_nx = RESP;
                else                 state_nx = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, index_q, {OFF_W{1'b0}}};
                word_we  = mem_rvalid;
                line_we  = last_beat;
                wr_off   = beat;
                wr_data  = mem_rdata;
                if (last_beat) state_nx = RESP;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_wack) begin
                    resp_valid = 1'b1;
                    resp_hit   = hit_q;
                    state_nx   = IDLE;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rd_data;
                resp_hit   = hit_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            beat         <= '0;
            hit_count    <= '0;
            access_count <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (state == LOOKUP) begin
                hit_q <= lookup_hit;
                if (access_count != '1) access_count <= access_count + COUNT_W'(1);
                if (lookup_hit && (hit_count != '1)) hit_count <= hit_count + COUNT_W'(1);
            end
            if ((state == REFILL) && mem_rvalid) begin
                beat <= last_beat ? '0 : beat + OFF_W'(1);
            end
        end
    end

    dm_cache_store #(
        .INDEX_W (INDEX_W),
        .OFF_W   (OFF_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_all (clear_all),
        .rd_index  (index_q),
        .rd_off    (off_q),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .word_we   (word_we),
        .wr_index  (index_q),
        .wr_off    (wr_off),
        .wr_data   (wr_data),
        .line_we   (line_we),
        .wr_tag    (tag_q)
    );

endmodule

// File: tb/tb_dm_cache_core.sv
// Bench for dm_cache_core: directed scenarios plus random traffic against a behavioural cache model.
module tb_dm_cache_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_wack = 1'b0;

    logic        req_ready, resp_valid, resp_hit, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_wdata, hit_count, access_count;
    logic [14:0] mem_addr;

    logic        req_ready_s, resp_valid_s, resp_hit_s, mem_req_s, mem_we_s;
    logic [31:0] resp_rdata_s, mem_wdata_s;
    logic [14:0] mem_addr_s;
    logic [3:0]  hit_count_s, access_count_s;

    always #5 clk = ~clk;

    dm_cache_core dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wack(mem_wack),
        .hit_count(hit_count), .access_count(access_count)
    );

    dm_cache_core #(.COUNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready_s), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_s), .resp_rdata(resp_rdata_s), .resp_hit(resp_hit_s),
        .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wack(mem_wack),
        .hit_count(hit_count_s), .access_count(access_count_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: which block each line holds, backing memory contents, access counts.
    bit          mv [1024];
    logic [2:0]  mt [1024];
    logic [31:0] mem_model [int];
    int          m_acc, m_hit;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] mem_get(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hC000_0000 | a;
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_clear_lines();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_lines();
        m_acc = 0;
        m_hit = 0;
        exp_q.delete();
    endtask

    task automatic do_req(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                          input int wack_dly, input bit gappy);
        int a, idx, tg, base, n, beats, last_at, mem_cycles;
        bit hit, done, seen_mem;
        logic [31:0] exp;
        a    = int'(addr);
        idx  = (a / 4) % 1024;
        tg   = a / 4096;
        base = a - (a % 4);
        hit  = mv[idx] && (mt[idx] == 3'(tg));
        m_acc++;
        if (hit) m_hit++;
        if (we) begin
            mem_model[a] = wd;
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(mem_get(a));
            if (!hit) begin
                mv[idx] = 1'b1;
                mt[idx] = 3'(tg);
            end
        end

        @(negedge clk);
        check_val("req_ready", req_ready, 1);
        check_val("req_ready_s", req_ready_s, 1);
        check_val("resp_idle", resp_valid, 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        n = 0; beats = 0; last_at = -10; mem_cycles = 0; seen_mem = 0; done = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            mem_rvalid = 1'b0;
            mem_wack   = 1'b0;
            if (mem_req) begin
                if (!seen_mem) begin
                    seen_mem = 1;
                    check_val("mem_we", mem_we, we);
                    check_val("mem_addr", mem_addr, we ? a : base);
                    check_val("mem_wdata", mem_wdata, we ? wd : 32'h0);
                    check_val("mem_req_s", mem_req_s, 1);
                    check_val("mem_we_s", mem_we_s, we);
                    check_val("mem_addr_s", mem_addr_s, we ? a : base);
                    check_val("mem_wdata_s", mem_wdata_s, we ? wd : 32'h0);
                end
                mem_cycles++;
                if (mem_we) begin
                    if (mem_cycles > wack_dly) mem_wack = 1'b1;
                end else if (beats < 4 && (!gappy || $urandom_range(1, 0) == 1)) begin
                    mem_rdata  = mem_get(base + beats);
                    mem_rvalid = 1'b1;
                    beats++;
                    if (beats == 4) last_at = n;
                end
            end
            #1;
            if (resp_valid) begin
                done = 1;
                exp  = exp_q.pop_front();
                check_val("resp_rdata", resp_rdata, exp);
                check_val("resp_hit", resp_hit, hit);
                check_val("resp_valid_s", resp_valid_s, 1);
                check_val("resp_rdata_s", resp_rdata_s, exp);
                check_val("resp_hit_s", resp_hit_s, hit);
                check_val("hit_count", hit_count, m_hit);
                check_val("access_count", access_count, m_acc);
                check_val("hit_count_sat", hit_count_s, sat15(m_hit));
                check_val("access_count_sat", access_count_s, sat15(m_acc));
                check_val("mem_used", seen_mem, we || !hit);
                if (!we && hit)  check_val("hit_latency", n, 2);
                if (!we && !hit) check_val("miss_latency", n, last_at + 1);
            end
        end
        if (!done) check_val("resp_timeout", 0, 1);
        @(posedge clk);
        #1;
        mem_wack   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int beats, tg, idx, off;
        bit reached;
        logic we;

        model_reset();
        mem_model[4] = 32'hA0;
        mem_model[5] = 32'hA1;
        mem_model[6] = 32'hA2;
        mem_model[7] = 32'hA3;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_hit_count", hit_count, 0);
        check_val("rst_access_count", access_count, 0);

        do_req(1'b0, 15'h0005, 32'h0, 0, 0);
        do_req(1'b0, 15'h0006, 32'h0, 0, 0);
        do_req(1'b0, 15'h1004, 32'h0, 0, 0);
        do_req(1'b0, 15'h0005, 32'h0, 0, 0);
        do_req(1'b1, 15'h0006, 32'hDEAD, 3, 0);
        do_req(1'b0, 15'h0006, 32'h0, 0, 0);
        do_req(1'b1, 15'h2000, 32'h1234_5678, 1, 0);
        do_req(1'b0, 15'h2000, 32'h0, 0, 0);

        // Flush with a simultaneous request: the request must not be taken.
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h0123;
        #1;
        check_val("flush_req_ready", req_ready, 0);
        check_val("flush_req_ready_s", req_ready_s, 0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear_lines();
        do_req(1'b0, 15'h0006, 32'h0, 0, 0);

        // Reset arriving together with refill beat 2.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 15'h0405;
        @(posedge clk);
        #1 req_valid = 1'b0;
        beats = 0;
        reached = 0;
        for (int i = 0; i < 30 && !reached; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (mem_req && !mem_we) begin
                mem_rdata  = mem_get(32'h404 + beats);
                mem_rvalid = 1'b1;
                if (beats == 2) begin
                    rst_n   = 1'b0;
                    reached = 1;
                end
                beats++;
            end
        end
        check_val("reset_reached_beat2", reached, 1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("abort_mem_req", mem_req, 0);
        check_val("abort_resp_valid", resp_valid, 0);
        check_val("abort_hit_count", hit_count, 0);
        check_val("abort_access_count", access_count, 0);
        check_val("abort_access_count_s", access_count_s, 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_val("abort_no_resp", resp_valid, 0);
        do_req(1'b0, 15'h0405, 32'h0, 0, 0);

        // Counter saturation on the 4-bit instance.
        do_req(1'b0, 15'h0005, 32'h0, 0, 0);
        for (int i = 0; i < 20; i++) do_req(1'b0, 15'h0006, 32'h0, 0, 0);
        check_val("sat_hit_count_s", hit_count_s, 15);
        check_val("sat_access_count_s", access_count_s, 15);

        // Random traffic over a few indices and tags to force hits, conflicts and writes.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
                model_clear_lines();
            end
            tg  = int'($urandom_range(7, 0));
            idx = int'($urandom_range(3, 0));
            off = int'($urandom_range(3, 0));
            we  = ($urandom_range(2, 0) == 0);
            do_req(we, 15'(tg * 4096 + idx * 4 + off), $urandom, int'($urandom_range(4, 0)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
